// File: rtl/otp_pkg.sv
// Shared definitions for the one-time-pad engine: mode encoding, default
// LFSR constants and the Galois LFSR step function.
package otp_pkg;

  // Request mode encoding on in_mode.
  localparam logic OTP_ENC = 1'b0;
  localparam logic OTP_DEC = 1'b1;

  // Default 8-bit Galois feedback taps and reset seed.
  localparam logic [7:0] DEF_POLY = 8'hB8;
  localparam logic [7:0] DEF_SEED = 8'h01;

  // Widest LFSR the step function handles; callers zero-extend and truncate.
  localparam int LFSR_MAX_W = 64;

  // One Galois step: shift right, fold the taps in when the bit shifted out is 1.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] value,
    input logic [LFSR_MAX_W-1:0] poly
  );
    return (value >> 1) ^ (value[0] ? poly : '0);
  endfunction

endpackage

// File: rtl/otp_lfsr.sv
// Pad generator: Galois LFSR that advances only when told to, with a
// synchronous reseed used by the engine's clear.
module otp_lfsr
  import otp_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(DEF_POLY),
  parameter logic [DATA_W-1:0] SEED      = DATA_W'(DEF_SEED)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reseed,
  input  logic              step,
  output logic [DATA_W-1:0] value
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [DATA_W-1:0] SEED_EFF = (SEED == '0) ? DATA_W'(1) : SEED;

  logic [DATA_W-1:0] next_value;

  // Next state from the shared step function.
  always_comb begin
    next_value = DATA_W'(lfsr_next(LFSR_MAX_W'(value), LFSR_MAX_W'(LFSR_POLY)));
  end

  // Hold, reseed or advance the register.
  always_ff @(posedge clk) begin
    if (rst || reseed) begin
      value <= SEED_EFF;
    end else if (step) begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/otp_pad_engine.sv
// One-time-pad encrypt/decrypt engine. Encrypt XORs data with a fresh LFSR
// pad and parks the pad in the lowest free slot; decrypt XORs with a stored
// pad and wipes that slot so each pad is used once.
//
// Handshake: a request transfers on a cycle where in_valid & in_ready; a
// result transfers on a cycle where out_valid & out_ready. in_valid/out_valid
// never depend on the opposite ready. While out_valid & ~out_ready the
// output register holds. in_ready = ~clear & (~out_valid | out_ready) is the
// only combinational path through the block.
module otp_pad_engine
  import otp_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                DEPTH     = 8,
  parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(DEF_POLY),
  parameter logic [DATA_W-1:0] SEED      = DATA_W'(DEF_SEED),
  localparam int               IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_err,
  output logic [IDX_W:0]    pad_count,
  output logic              full
);

  logic [DATA_W-1:0] pads [DEPTH];
  logic [DEPTH-1:0]  occupied;
  logic [DATA_W-1:0] lfsr_value;
  logic [IDX_W-1:0]  free_idx;
  logic              accept;
  logic              is_enc;
  logic              slot_used;
  logic              enc_ok;
  logic              dec_ok;

  otp_lfsr #(
    .DATA_W    (DATA_W),
    .LFSR_POLY (LFSR_POLY),
    .SEED      (SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .reseed (clear),
    .step   (enc_ok),
    .value  (lfsr_value)
  );

  // Handshake and request qualification.
  always_comb begin
    in_ready  = ~clear & (~out_valid | out_ready);
    accept    = in_valid & in_ready;
    full      = (pad_count == (IDX_W+1)'(DEPTH));
    is_enc    = (in_mode == OTP_ENC);
    slot_used = occupied[in_idx];
    enc_ok    = accept & is_enc & ~full;
    dec_ok    = accept & ~is_enc & slot_used;
  end

  // Lowest-index empty slot; scanning downward lets the lowest hit win.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!occupied[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  // Pad store, occupancy and count; clear wipes everything but the output.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      occupied  <= '0;
      pad_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pads[i] <= '0;
      end
    end else if (enc_ok) begin
      occupied[free_idx] <= 1'b1;
      pads[free_idx]     <= lfsr_value;
      pad_count          <= pad_count + 1'b1;
    end else if (dec_ok) begin
      occupied[in_idx] <= 1'b0;
      pads[in_idx]     <= '0;
      pad_count        <= pad_count - 1'b1;
    end
  end

  // One-deep output register; loads on accept, empties on a drained transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      if (is_enc) begin
        out_err  <= full;
        out_data <= full ? '0 : (in_data ^ lfsr_value);
        out_idx  <= full ? '0 : free_idx;
      end else begin
        out_err  <= ~slot_used;
        out_data <= slot_used ? (in_data ^ pads[in_idx]) : '0;
        out_idx  <= in_idx;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
